// File: rtl/adder_rr_scheduler.sv
// Round-robin arbiter sharing one fixed-latency adder among N_REQ requesters.
// One operation in flight; operands held on the adder, sum returned tagged with requester id.
module adder_rr_scheduler #(
   parameter int unsigned N_REQ       = 3,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADD_LATENCY = 1,
   localparam int unsigned ID_W       = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DATA_W-1:0]   req_a,
   input  logic [N_REQ*DATA_W-1:0]   req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         add_a,
   output logic [DATA_W-1:0]         add_b,
   input  logic [DATA_W-1:0]         add_x,
   output logic                      busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SCAN_W = ID_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ID_W-1:0]     r_rr_ptr;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_add_a;
   logic [DATA_W-1:0]   r_add_b;
   logic [DATA_W-1:0]   r_rsp_data;
   logic [ID_W-1:0]     r_rsp_id;
   logic                r_rsp_valid;
   logic                r_busy;

   logic                w_grant_found;
   logic [ID_W-1:0]     w_grant_idx;
   logic [SCAN_W-1:0]   w_scan_idx;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic [DATA_W-1:0]   w_sel_a;
   logic [DATA_W-1:0]   w_sel_b;
   logic [N_REQ-1:0]    w_req_ready;
   logic                w_accept;
   logic                w_sample;
   logic                w_rsp_done;

   // Round-robin search starting at r_rr_ptr, wrapping modulo N_REQ
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_scan_idx    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_scan_idx = {1'b0, r_rr_ptr} + SCAN_W'(k);
         if (w_scan_idx >= SCAN_W'(N_REQ)) begin
            w_scan_idx = w_scan_idx - SCAN_W'(N_REQ);
         end
         if (!w_grant_found && req_valid[w_scan_idx[ID_W-1:0]]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_scan_idx[ID_W-1:0];
         end
      end
   end

   assign w_ptr_nxt = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : (w_grant_idx + ID_W'(1));

   // Operand slice of the granted requester
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_grant_idx == ID_W'(i)) begin
            w_sel_a = req_a[i*DATA_W +: DATA_W];
            w_sel_b = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_grant_found)        w_state_nxt = ST_WAIT;
         ST_WAIT: if (r_cnt == '0)          w_state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready)            w_state_nxt = ST_IDLE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
   end

   // Output/control decode; the grant is offered combinationally only while idle
   always_comb begin
      w_req_ready = '0;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_found) begin
               w_req_ready = N_REQ'(1) << w_grant_idx;
               w_accept    = 1'b1;
            end
         end
         ST_WAIT: w_sample   = (r_cnt == '0);
         ST_RESP: w_rsp_done = rsp_ready & r_rsp_valid;
         default: ;
      endcase
   end

   // Datapath: operand capture, latency count, response hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_rsp_data  <= '0;
         r_rsp_id    <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_add_a  <= w_sel_a;
            r_add_b  <= w_sel_b;
            r_rsp_id <= w_grant_idx;
            r_rr_ptr <= w_ptr_nxt;
            r_cnt    <= CNT_W'(ADD_LATENCY);
         end
         if (r_state == ST_WAIT) begin
            if (w_sample) begin
               r_rsp_data  <= add_x;
               r_rsp_valid <= 1'b1;
            end else begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
         if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign busy      = r_busy;

   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

   a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: three instances (adder latency 0, 1, 3) share stimulus and are
// checked every cycle against a transaction-level model, plus directed literal expectations.
module tb_adder_rr_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_a = '0;
   logic [23:0] req_b = '0;
   logic        rsp_ready = 1'b1;

   logic [2:0]  rdy0, rdy1, rdy3;
   logic        rv0, rv1, rv3;
   logic [7:0]  dat0, dat1, dat3;
   logic [1:0]  id0, id1, id3;
   logic [7:0]  aa0, aa1, aa3, ab0, ab1, ab3;
   logic [7:0]  ax0, ax1, ax3;
   logic        bsy0, bsy1, bsy3;
   logic [7:0]  pipe3 [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adder_rr_scheduler #(.N_REQ(3), .DATA_W(8), .ADD_LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0), .req_a(req_a),
      .req_b(req_b), .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(dat0), .rsp_id(id0),
      .add_a(aa0), .add_b(ab0), .add_x(ax0), .busy(bsy0));

   adder_rr_scheduler #(.N_REQ(3), .DATA_W(8), .ADD_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .req_a(req_a),
      .req_b(req_b), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(dat1), .rsp_id(id1),
      .add_a(aa1), .add_b(ab1), .add_x(ax1), .busy(bsy1));

   adder_rr_scheduler #(.N_REQ(3), .DATA_W(8), .ADD_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3), .req_a(req_a),
      .req_b(req_b), .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_data(dat3), .rsp_id(id3),
      .add_a(aa3), .add_b(ab3), .add_x(ax3), .busy(bsy3));

   // Adder models: the sum appears L cycles after its operands settle
   assign ax0 = aa0 + ab0;

   always @(posedge clk or posedge reset) begin
      if (reset) ax1 <= '0;
      else       ax1 <= aa1 + ab1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe3[0] <= '0; pipe3[1] <= '0; pipe3[2] <= '0;
      end else begin
         pipe3[0] <= aa3 + ab3;
         pipe3[1] <= pipe3[0];
         pipe3[2] <= pipe3[1];
      end
   end
   assign ax3 = pipe3[2];

   // Gather outputs so index d addresses latency lat[d]
   logic [2:0] o_rdy [3];
   logic       o_rv  [3];
   logic [7:0] o_dat [3];
   logic [1:0] o_id  [3];
   logic [7:0] o_aa  [3];
   logic [7:0] o_ab  [3];
   logic       o_bsy [3];
   always_comb begin
      o_rdy[0] = rdy0; o_rdy[1] = rdy1; o_rdy[2] = rdy3;
      o_rv[0]  = rv0;  o_rv[1]  = rv1;  o_rv[2]  = rv3;
      o_dat[0] = dat0; o_dat[1] = dat1; o_dat[2] = dat3;
      o_id[0]  = id0;  o_id[1]  = id1;  o_id[2]  = id3;
      o_aa[0]  = aa0;  o_aa[1]  = aa1;  o_aa[2]  = aa3;
      o_ab[0]  = ab0;  o_ab[1]  = ab1;  o_ab[2]  = ab3;
      o_bsy[0] = bsy0; o_bsy[1] = bsy1; o_bsy[2] = bsy3;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted op yields its sum L+2 cycles later, held until taken
   int         lat [3] = '{0, 1, 3};
   int         m_ptr [3];
   bit         m_busy [3];
   bit         m_rv [3];
   int         m_left [3];
   logic [7:0] m_aa [3];
   logic [7:0] m_ab [3];
   logic [7:0] m_sum [3];
   logic [7:0] m_data [3];
   logic [1:0] m_id [3];

   function automatic int pick(input int ptr);
      for (int k = 0; k < 3; k++) begin
         if (req_valid[(ptr + k) % 3]) return (ptr + k) % 3;
      end
      return -1;
   endfunction

   function automatic logic [2:0] exp_rdy(input int d);
      int g;
      if (m_busy[d]) return 3'b000;
      g = pick(m_ptr[d]);
      if (g < 0) return 3'b000;
      return 3'(1 << g);
   endfunction

   always @(posedge clk or posedge reset) begin : model
      int g;
      for (int d = 0; d < 3; d++) begin
         if (reset) begin
            m_ptr[d] = 0; m_busy[d] = 0; m_rv[d] = 0; m_left[d] = 0;
            m_aa[d] = '0; m_ab[d] = '0; m_sum[d] = '0; m_data[d] = '0; m_id[d] = '0;
         end else if (!m_busy[d]) begin
            g = pick(m_ptr[d]);
            if (g >= 0) begin
               m_aa[d]   = req_a[g*8 +: 8];
               m_ab[d]   = req_b[g*8 +: 8];
               m_sum[d]  = m_aa[d] + m_ab[d];
               m_id[d]   = 2'(g);
               m_ptr[d]  = (g + 1) % 3;
               m_busy[d] = 1;
               m_left[d] = lat[d] + 1;
            end
         end else if (!m_rv[d]) begin
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
               m_rv[d]   = 1;
               m_data[d] = m_sum[d];
            end
         end else if (rsp_ready) begin
            m_rv[d]   = 0;
            m_busy[d] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("L%0d_req_ready", lat[d]), 32'(o_rdy[d]), 32'(exp_rdy(d)));
         chk($sformatf("L%0d_rsp_valid", lat[d]), 32'(o_rv[d]),  32'(m_rv[d]));
         chk($sformatf("L%0d_rsp_data", lat[d]),  32'(o_dat[d]), 32'(m_data[d]));
         chk($sformatf("L%0d_rsp_id", lat[d]),    32'(o_id[d]),  32'(m_id[d]));
         chk($sformatf("L%0d_add_a", lat[d]),     32'(o_aa[d]),  32'(m_aa[d]));
         chk($sformatf("L%0d_add_b", lat[d]),     32'(o_ab[d]),  32'(m_ab[d]));
         chk($sformatf("L%0d_busy", lat[d]),      32'(o_bsy[d]), 32'(m_busy[d]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         gq [$];
      logic [1:0] rid [$];
      logic [7:0] rdat [$];
      logic [7:0] exp_sum [3];
      bit         seen;
      int         n;

      exp_sum[0] = 8'h03; exp_sum[1] = 8'h30; exp_sum[2] = 8'h10;

      // Power-on reset values
      #1 reset = 1'b1;
      repeat (2) tick();
      mid();
      chk("rst_ready", 32'(rdy1), 32'h0);
      chk("rst_rsp_valid", 32'(rv1), 32'h0);
      chk("rst_rsp_data", 32'(dat1), 32'h0);
      chk("rst_rsp_id", 32'(id1), 32'h0);
      chk("rst_add_a", 32'(aa1), 32'h0);
      chk("rst_busy", 32'(bsy1), 32'h0);
      tick(); reset = 1'b0;
      tick();

      // Single op from requester 0; latency sweep on the same stimulus
      req_valid = 3'b001; req_a = 24'h000012; req_b = 24'h000034;
      mid();
      chk("single_ready", 32'(rdy1), 32'h1);
      tick(); req_valid = 3'b000;
      mid();
      for (int c = 1; c <= 6; c++) begin
         chk("lat0_rsp_valid", 32'(rv0), 32'(c == 2));
         chk("lat1_rsp_valid", 32'(rv1), 32'(c == 3));
         chk("lat3_rsp_valid", 32'(rv3), 32'(c == 5));
         if (c == 2) chk("lat0_rsp_data", 32'(dat0), 32'h46);
         if (c == 3) begin
            chk("single_rsp_data", 32'(dat1), 32'h46);
            chk("single_rsp_id", 32'(id1), 32'h0);
         end
         if (c == 5) chk("lat3_rsp_data", 32'(dat3), 32'h46);
         tick(); mid();
      end

      // Wrap-around sum from requester 2
      tick();
      req_valid = 3'b100; req_a = 24'hFF0000; req_b = 24'h010000;
      mid();
      chk("wrap_ready", 32'(rdy1), 32'h4);
      tick(); req_valid = 3'b000;
      mid();
      seen = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (rv1) begin
            seen = 1'b1;
            chk("wrap_rsp_data", 32'(dat1), 32'h00);
            chk("wrap_rsp_id", 32'(id1), 32'h2);
            chk("wrap_latency", 32'(c), 32'd3);
         end
         tick(); mid();
      end
      chk("wrap_seen", 32'(seen), 32'h1);

      // Fairness with all requesters held valid
      tick();
      req_valid = 3'b111; req_a = 24'h801001; req_b = 24'h902002;
      mid();
      for (int c = 0; c < 26; c++) begin
         if (rdy1 != 3'b000) gq.push_back((rdy1 == 3'b001) ? 0 : ((rdy1 == 3'b010) ? 1 : 2));
         if (rv1) begin
            rid.push_back(id1);
            rdat.push_back(dat1);
         end
         tick(); mid();
      end
      chk("fair_grant_count", 32'(gq.size() >= 6), 32'h1);
      chk("fair_rsp_count", 32'(rid.size() >= 6), 32'h1);
      n = (gq.size() < 6) ? gq.size() : 6;
      for (int i = 0; i < n; i++) chk("fair_grant_order", 32'(gq[i]), 32'(i % 3));
      n = (rid.size() < 6) ? rid.size() : 6;
      for (int i = 0; i < n; i++) begin
         chk("fair_rsp_id", 32'(rid[i]), 32'(i % 3));
         chk("fair_rsp_data", 32'(rdat[i]), 32'(exp_sum[i % 3]));
      end
      tick(); req_valid = 3'b000;
      repeat (10) tick();

      // Backpressure: pointer sits at 1 after seven grants
      rsp_ready = 1'b0; req_valid = 3'b011; req_a = 24'h000521; req_b = 24'h000722;
      mid();
      chk("bp_first_ready", 32'(rdy1), 32'h2);
      tick(); req_valid = 3'b001;
      tick(); tick();
      mid();
      for (int c = 0; c < 10; c++) begin
         chk("bp_rsp_valid", 32'(rv1), 32'h1);
         chk("bp_rsp_data", 32'(dat1), 32'h0C);
         chk("bp_rsp_id", 32'(id1), 32'h1);
         chk("bp_ready", 32'(rdy1), 32'h0);
         chk("bp_busy", 32'(bsy1), 32'h1);
         if (c < 9) begin
            tick(); mid();
         end
      end
      tick(); rsp_ready = 1'b1;
      mid();
      chk("bp_hs_ready", 32'(rdy1), 32'h0);
      tick();
      mid();
      chk("bp_next_ready", 32'(rdy1), 32'h1);
      chk("bp_rsp_dropped", 32'(rv1), 32'h0);
      tick(); req_valid = 3'b000;
      repeat (10) tick();

      // Reset while operations wait on the adder
      req_valid = 3'b001; req_a = 24'h000003; req_b = 24'h000004;
      tick(); req_valid = 3'b000; reset = 1'b1;
      mid();
      chk("midrst_rsp_valid", 32'(rv1), 32'h0);
      chk("midrst_rsp_data", 32'(dat1), 32'h0);
      chk("midrst_add_a", 32'(aa1), 32'h0);
      chk("midrst_add_b", 32'(ab1), 32'h0);
      chk("midrst_busy", 32'(bsy1), 32'h0);
      chk("midrst_busy_lat3", 32'(bsy3), 32'h0);
      tick(); reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         mid();
         chk("midrst_no_rsp0", 32'(rv0), 32'h0);
         chk("midrst_no_rsp1", 32'(rv1), 32'h0);
         chk("midrst_no_rsp3", 32'(rv3), 32'h0);
         tick();
      end
      req_valid = 3'b101; req_a = 24'h000000; req_b = 24'h000000;
      mid();
      chk("midrst_ptr_zero", 32'(rdy1), 32'h1);
      tick(); req_valid = 3'b000;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
